// File: rtl/lif_neuron_scheduler.sv
// -----------------------------------------------------------------------------
// lif_neuron_scheduler
//
// Shares one leaky integrate-and-fire update datapath across N_NEURONS neurons.
// Each neuron has a membrane potential register v[i] and an input current
// register cur[i]. A start pulse in IDLE begins one timestep. The sweep visits
// the neurons in index order, one UPDATE cycle per neuron. A neuron that reaches
// THRESH produces one spike event, and the event is handed to the consumer
// through a valid/ready handshake.
//
// Handshake: the event transfers on a rising clock edge where spike_valid and
// spike_ready are both high. While spike_valid is high and the transfer has not
// happened, spike_valid and spike_idx do not change. spike_valid goes low in the
// cycle after the transfer.
//
// Optional feature (macro LIF_REFRACTORY_EN): each neuron gets a refractory
// flag, which is set when the neuron spikes. On the next sweep a flagged neuron
// is held at v=0, does not spike, and its flag is cleared. When the macro is not
// defined there are no flags, and every neuron integrates on every sweep.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous reset, active-high
//   cur_we       in   write enable for the input current register
//   cur_widx     in   index of the current register to write
//   cur_wdata    in   current value to write
//   start        in   begin one timestep sweep (ignored unless IDLE)
//   busy         out  high in any state other than IDLE
//   done         out  one-cycle pulse when the sweep completes
//   spike_valid  out  a spike event is available
//   spike_idx    out  index of the spiking neuron
//   spike_ready  in   the consumer accepts the event
//   spike_vec    out  per-neuron spike flags from the last sweep
//   state_dbg    out  current FSM state (0 IDLE, 1 UPDATE, 2 EMIT, 3 DONE)
// -----------------------------------------------------------------------------
module lif_neuron_scheduler #(
    parameter int N_NEURONS  = 4,
    parameter int IDX_W      = 2,
    parameter int W          = 5,
    parameter int THRESH     = 15,
    parameter int LEAK_SHIFT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cur_we,
    input  logic [IDX_W-1:0]     cur_widx,
    input  logic [W-1:0]         cur_wdata,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 spike_valid,
    output logic [IDX_W-1:0]     spike_idx,
    input  logic                 spike_ready,
    output logic [N_NEURONS-1:0] spike_vec,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_EMIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [W:0]       THRESH_EXT = (W+1)'(THRESH);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_NEURONS - 1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [W-1:0]     cur [N_NEURONS];
    logic [W-1:0]     v   [N_NEURONS];

`ifdef LIF_REFRACTORY_EN
    logic [N_NEURONS-1:0] refr;
`endif

    // Datapath for the neuron at ptr. The sum is one bit wider than W, so a
    // large current plus the leaked potential does not wrap around.
    logic [W-1:0] cur_sel;
    logic [W-1:0] v_sel;
    logic [W:0]   ns;
    logic         fire;
    logic         last;
    logic         refr_hit;

    always_comb begin
        cur_sel = cur[ptr];
        v_sel   = v[ptr];
        ns      = {1'b0, cur_sel} + ({1'b0, v_sel} >> LEAK_SHIFT);
        fire    = (ns >= THRESH_EXT);
        last    = (ptr == LAST_IDX);
`ifdef LIF_REFRACTORY_EN
        refr_hit = refr[ptr];
`else
        refr_hit = 1'b0;
`endif
    end

    assign state_dbg = state;

    // Current writes are accepted in every state. A write to the neuron being
    // updated in the same cycle stores the new value, and the update uses the
    // old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_NEURONS; i++) cur[i] <= '0;
        end else if (cur_we) begin
            cur[cur_widx] <= cur_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            ptr         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
            spike_vec   <= '0;
            for (int i = 0; i < N_NEURONS; i++) v[i] <= '0;
`ifdef LIF_REFRACTORY_EN
            refr        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_UPDATE;
                        busy  <= 1'b1;
                    end
                end

                S_UPDATE: begin
                    if (!refr_hit && fire) begin
                        v[ptr]         <= '0;
                        spike_vec[ptr] <= 1'b1;
                        spike_idx      <= ptr;
                        spike_valid    <= 1'b1;
                        state          <= S_EMIT;
`ifdef LIF_REFRACTORY_EN
                        refr[ptr]      <= 1'b1;
`endif
                    end else begin
                        // A refractory neuron is held at zero. Otherwise the
                        // sum is below THRESH, so it fits in W bits.
                        v[ptr]         <= refr_hit ? '0 : ns[W-1:0];
                        spike_vec[ptr] <= 1'b0;
`ifdef LIF_REFRACTORY_EN
                        refr[ptr]      <= 1'b0;
`endif
                        if (last) begin
                            ptr   <= '0;
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            ptr   <= ptr + IDX_W'(1);
                        end
                    end
                end

                S_EMIT: begin
                    // Hold the event until it transfers. No neuron updates in
                    // this state.
                    if (spike_ready) begin
                        spike_valid <= 1'b0;
                        if (last) begin
                            ptr   <= '0;
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            ptr   <= ptr + IDX_W'(1);
                            state <= S_UPDATE;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
